// File: rtl/down_counter.sv
// Loadable down-counter/timer with a valid/ready load port, expiry pulse and
// a non-wrap flag for chaining. `DOWN_COUNTER_RELOAD_EN adds periodic auto-reload.

module dec #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);
  assign out_o = in_i - WIDTH'(1);
endmodule

module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired,
  output logic             cont
);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] count_dec;

  dec #(.WIDTH(WIDTH)) u_dec (.in_i(count_q), .out_o(count_dec));

`ifdef DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reload_q <= '0;
    else        reload_q <= reload_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
`ifdef DOWN_COUNTER_RELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          count_d = load_value;
`ifdef DOWN_COUNTER_RELOAD_EN
          reload_d = load_value;
`endif
          state_d = (load_value != '0) ? RUN : EXPIRE;
        end
      end
      RUN: begin
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (en) begin
          // Leave RUN on the 1->0 step so the wrapped value is never stored
          count_d = count_dec;
          if (count_q == WIDTH'(1)) state_d = EXPIRE;
        end
      end
      EXPIRE: begin
        count_d = '0;
        state_d = IDLE;
`ifdef DOWN_COUNTER_RELOAD_EN
        if (!abort && reload_q != '0) begin
          count_d = reload_q;
          state_d = RUN;
        end
`endif
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign expired    = (state_q == EXPIRE);
  assign count      = count_q;
  assign cont       = (count_q != '0);

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter (WIDTH=4); reload steps run
// only when DOWN_COUNTER_RELOAD_EN is defined.

module tb_down_counter;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             en;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             expired;
  logic             cont;

  int total = 0;
  int bad   = 0;

  down_counter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .en(en), .abort(abort), .count(count),
    .busy(busy), .expired(expired), .cont(cont)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample 1 time unit after the rising edge, then drive next inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic b,
                         input logic e, input logic lr);
    check({tag, ".count"},   32'(count),      32'(c));
    check({tag, ".busy"},    32'(busy),       32'(b));
    check({tag, ".expired"}, 32'(expired),    32'(e));
    check({tag, ".ready"},   32'(load_ready), 32'(lr));
    check({tag, ".cont"},    32'(cont),       32'(c != 4'd0));
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_value = '0; en = 1'b0; abort = 1'b0;
    #3;
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b1);
    #4 rst_n = 1'b1;

    // Load 5, en held high: 5,4,3,2,1 in RUN, then EXPIRE, then IDLE
    tick();
    load_valid = 1'b1; load_value = 4'd5; en = 1'b1;
    tick();
    load_valid = 1'b0;
    chk_all("l5.run5", 4'd5, 1'b1, 1'b0, 1'b0);
    for (int i = 4; i >= 1; i--) begin
      tick();
      chk_all($sformatf("l5.run%0d", i), 4'(i), 1'b1, 1'b0, 1'b0);
    end
    tick();
    chk_all("l5.exp", 4'd0, 1'b0, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0; en = 1'b0;
    chk_all("l5.idle", 4'd0, 1'b0, 1'b0, 1'b1);

    // Load 3, en pattern 1,0,0,1,1
    load_valid = 1'b1; load_value = 4'd3;
    tick();
    load_valid = 1'b0;
    chk_all("l3.run3", 4'd3, 1'b1, 1'b0, 1'b0);
    en = 1'b1; tick(); chk_all("l3.e1", 4'd2, 1'b1, 1'b0, 1'b0);
    en = 1'b0; tick(); chk_all("l3.e0a", 4'd2, 1'b1, 1'b0, 1'b0);
    en = 1'b0; tick(); chk_all("l3.e0b", 4'd2, 1'b1, 1'b0, 1'b0);
    en = 1'b1; tick(); chk_all("l3.e1b", 4'd1, 1'b1, 1'b0, 1'b0);
    en = 1'b1; tick(); chk_all("l3.exp", 4'd0, 1'b0, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0; en = 1'b0;
    chk_all("l3.idle", 4'd0, 1'b0, 1'b0, 1'b1);

    // Load 0 goes straight to EXPIRE
    load_valid = 1'b1; load_value = 4'd0;
    tick();
    load_valid = 1'b0;
    chk_all("l0.exp", 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("l0.idle", 4'd0, 1'b0, 1'b0, 1'b1);

    // Load 9, ignored load offer during RUN, abort beats en
    load_valid = 1'b1; load_value = 4'd9; en = 1'b1;
    tick();
    load_value = 4'd4;
    chk_all("l9.run9", 4'd9, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("l9.run8", 4'd8, 1'b1, 1'b0, 1'b0);
    load_valid = 1'b0;
    tick();
    chk_all("l9.run7", 4'd7, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0; en = 1'b0;
    chk_all("l9.abort", 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("l9.stay", 4'd0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-RUN at count 6
    load_valid = 1'b1; load_value = 4'd8; en = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    chk_all("ar.run6", 4'd6, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("ar.async", 4'd0, 1'b0, 1'b0, 1'b1);
    #1 rst_n = 1'b1; en = 1'b0;
    tick();
    chk_all("ar.after", 4'd0, 1'b0, 1'b0, 1'b1);

`ifdef DOWN_COUNTER_RELOAD_EN
    // Periodic reload of 2: 2,1,0,2,1,0 then abort in EXPIRE
    load_valid = 1'b1; load_value = 4'd2; en = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int p = 0; p < 2; p++) begin
      chk_all($sformatf("rl%0d.r2", p), 4'd2, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all($sformatf("rl%0d.r1", p), 4'd1, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all($sformatf("rl%0d.exp", p), 4'd0, 1'b0, 1'b1, 1'b0);
      if (p == 1) abort = 1'b1;
      tick();
    end
    abort = 1'b0; en = 1'b0;
    chk_all("rl.abort", 4'd0, 1'b0, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
